// File: rtl/iir_coeff_ctrl.sv
//-----------------------------------------------------------------------------
// iir_coeff_ctrl
//
// Run-time coefficient configurator and sequencer for a chain of second-order
// IIR sections (Q2.22). Coefficient writes land in a shadow bank. A commit
// stops new samples, waits for the samples already inside the filter chain
// to come out, copies the shadow bank into the active bank in a single edge,
// and then holds a flush pulse so that every section restarts from a clean
// delay line using the new coefficients.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   cfg_we       coefficient write strobe
//   cfg_addr     coefficient index s*COEFFS_PER_SECTION+k (b0,b1,b2,a1,a2)
//   cfg_wdata    coefficient value, Q2.22
//   cfg_commit   one-cycle request to apply the shadow bank
//   cfg_err_clr  clears cfg_err
//   cfg_busy     high whenever the sequencer is not idle
//   cfg_err      sticky error flag (bad address, write while busy,
//                unexpected filter output, drain timeout)
//   s_valid_in   upstream sample valid
//   s_data_in    upstream sample
//   s_ready      upstream may present a sample
//   f_valid_in   sample valid towards the filter chain
//   f_data_in    sample towards the filter chain
//   f_valid_out  valid returned from the end of the filter chain
//   filt_flush   clear the delay-line state of all sections
//   coeff_flat   active coefficients, word i at bits [COEFF_W*i +: COEFF_W]
//-----------------------------------------------------------------------------
module iir_coeff_ctrl #(
    parameter int NUM_SECTIONS       = 4,
    parameter int COEFFS_PER_SECTION = 5,
    parameter int COEFF_W            = 24,
    parameter int PIPE_LAT           = 8,
    parameter int FLUSH_CYC          = 8,
    parameter int DRAIN_TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cfg_we,
    input  logic [4:0]           cfg_addr,
    input  logic [COEFF_W-1:0]   cfg_wdata,
    input  logic                 cfg_commit,
    input  logic                 cfg_err_clr,
    output logic                 cfg_busy,
    output logic                 cfg_err,

    input  logic                 s_valid_in,
    input  logic [COEFF_W-1:0]   s_data_in,
    output logic                 s_ready,

    output logic                 f_valid_in,
    output logic [COEFF_W-1:0]   f_data_in,
    input  logic                 f_valid_out,
    output logic                 filt_flush,

    output logic [NUM_SECTIONS*COEFFS_PER_SECTION*COEFF_W-1:0] coeff_flat
);

    localparam int NUM_COEFFS = NUM_SECTIONS * COEFFS_PER_SECTION;

    // Counter widths sized so the largest value each counter reaches fits.
    localparam int INF_W = $clog2(PIPE_LAT + 2);        // 0 .. PIPE_LAT+1
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);   // 0 .. DRAIN_TIMEOUT-1
    localparam int FLS_W = $clog2(FLUSH_CYC + 1);       // 0 .. FLUSH_CYC-1

    localparam logic [INF_W-1:0] INF_MAX   = INF_W'(PIPE_LAT + 1);
    localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [FLS_W-1:0] FLS_LAST  = FLS_W'(FLUSH_CYC - 1);
    localparam logic [4:0]       ADDR_LIM  = 5'(NUM_COEFFS);

    // 1.0 in Q2.22: only the integer LSB set.
    localparam logic [COEFF_W-1:0] COEFF_ONE = {2'b01, {(COEFF_W-2){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWAP,
        ST_FLUSH
    } state_t;

    // Passthrough section: b0 = 1.0, every other coefficient 0.
    function automatic logic [COEFF_W-1:0] passthrough_coeff(input int idx);
        return ((idx % COEFFS_PER_SECTION) == 0) ? COEFF_ONE : '0;
    endfunction

    //-------------------------------------------------------------------------
    // Registers and wires
    //-------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;

    logic [COEFF_W-1:0]   r_shadow [NUM_COEFFS];
    logic [COEFF_W-1:0]   r_active [NUM_COEFFS];

    logic [INF_W-1:0]     r_inflight;
    logic [DRN_W-1:0]     r_drain_cnt;
    logic [FLS_W-1:0]     r_flush_cnt;
    logic                 r_err;

    logic                 w_idle;
    logic                 w_addr_ok;
    logic                 w_wr_accept;
    logic                 w_wr_err;
    logic                 w_stray_ret;
    logic                 w_timeout;
    logic                 w_err_set;

    //-------------------------------------------------------------------------
    // Decode of the current cycle's events
    //-------------------------------------------------------------------------
    assign w_idle      = (r_state == ST_IDLE);
    assign w_addr_ok   = (cfg_addr < ADDR_LIM);
    assign w_wr_accept = cfg_we & w_idle & w_addr_ok;
    // Any write that is not accepted is an error: bad index or busy sequencer.
    assign w_wr_err    = cfg_we & ~(w_idle & w_addr_ok);
    // A filter output with nothing outstanding means the chain and this block
    // disagree about what is in flight.
    assign w_stray_ret = f_valid_out & (r_inflight == '0);
    // Timeout fires in the last allowed DRAIN cycle, only if still not empty.
    assign w_timeout   = (r_state == ST_DRAIN) & (r_inflight != '0) &
                         (r_drain_cnt == DRN_LAST);
    assign w_err_set   = w_wr_err | w_stray_ret | w_timeout;

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next-state logic
    //-------------------------------------------------------------------------
    // NOTE: the default assignment at the top of each combinational process
    // keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_commit) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_inflight == '0) || w_timeout) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_flush_cnt == FLS_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // FSM: outputs
    //-------------------------------------------------------------------------
    always_comb begin
        s_ready    = 1'b0;
        cfg_busy   = 1'b1;
        filt_flush = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_ready  = 1'b1;
                cfg_busy = 1'b0;
            end
            ST_FLUSH: begin
                filt_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sample path is purely combinational; gating happens through s_ready.
    assign f_valid_in = s_valid_in & s_ready;
    assign f_data_in  = s_data_in;

    //-------------------------------------------------------------------------
    // In-flight sample counter
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else if (w_timeout) begin
            // Give up on the missing samples so the next commit starts clean.
            r_inflight <= '0;
        end else if (f_valid_in && !f_valid_out) begin
            if (r_inflight != INF_MAX) begin
                r_inflight <= r_inflight + INF_W'(1);
            end
        end else if (!f_valid_in && f_valid_out) begin
            if (r_inflight != '0) begin
                r_inflight <= r_inflight - INF_W'(1);
            end
        end
    end

    //-------------------------------------------------------------------------
    // DRAIN and FLUSH cycle counters; both sit at 0 outside their state so
    // each visit starts counting from the first cycle.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRN_W'(1) : '0;
            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + FLS_W'(1) : '0;
        end
    end

    //-------------------------------------------------------------------------
    // Coefficient banks
    //-------------------------------------------------------------------------
    // NOTE: both banks are reset to defined passthrough values, so they are
    // built as reset flops rather than an unreset RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                r_shadow[i] <= passthrough_coeff(i);
            end
        end else if (w_wr_accept) begin
            r_shadow[cfg_addr] <= cfg_wdata;
        end
    end

    // The whole active bank changes on one edge, in SWAP only, so the filter
    // never sees a mix of old and new coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                r_active[i] <= passthrough_coeff(i);
            end
        end else if (r_state == ST_SWAP) begin
            r_active <= r_shadow;
        end
    end

    always_comb begin
        coeff_flat = '0;
        for (int i = 0; i < NUM_COEFFS; i++) begin
            coeff_flat[COEFF_W*i +: COEFF_W] = r_active[i];
        end
    end

    //-------------------------------------------------------------------------
    // Sticky error flag: a new error in the same cycle as a clear wins.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (cfg_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign cfg_err = r_err;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
//-----------------------------------------------------------------------------
// tb_iir_coeff_ctrl
//
// Directed sequence with randomized coefficient and sample data. Expected
// coefficients come from shadow/active arrays kept by the bench; the filter
// chain is modelled as a fixed 6-cycle return delay, and the expected DRAIN
// length is derived from the last pending return time.
//-----------------------------------------------------------------------------
module tb_iir_coeff_ctrl;

    localparam int NC        = 20;
    localparam int CW        = 24;
    localparam int FLUSH_CYC = 8;
    localparam int DRAIN_TO  = 64;
    localparam int RET_DLY   = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [4:0]     cfg_addr;
    logic [CW-1:0]  cfg_wdata;
    logic           cfg_commit;
    logic           cfg_err_clr;
    logic           cfg_busy;
    logic           cfg_err;
    logic           s_valid_in;
    logic [CW-1:0]  s_data_in;
    logic           s_ready;
    logic           f_valid_in;
    logic [CW-1:0]  f_data_in;
    logic           f_valid_out;
    logic           filt_flush;
    logic [479:0]   coeff_flat;

    logic           mdl_fvo = 1'b0;
    logic           man_fvo;
    logic           ret_en;

    int             cyc = 0;
    int             total = 0;
    int             bad = 0;
    int             due_q[$];

    logic [CW-1:0]  exp_shadow [NC];
    logic [CW-1:0]  exp_active [NC];

    always #5 clk = ~clk;

    assign f_valid_out = mdl_fvo | man_fvo;

    iir_coeff_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_err_clr (cfg_err_clr),
        .cfg_busy    (cfg_busy),
        .cfg_err     (cfg_err),
        .s_valid_in  (s_valid_in),
        .s_data_in   (s_data_in),
        .s_ready     (s_ready),
        .f_valid_in  (f_valid_in),
        .f_data_in   (f_data_in),
        .f_valid_out (f_valid_out),
        .filt_flush  (filt_flush),
        .coeff_flat  (coeff_flat)
    );

    // Filter chain model: each accepted sample returns RET_DLY cycles later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            due_q.delete();
            mdl_fvo <= 1'b0;
        end else begin
            if (mdl_fvo) void'(due_q.pop_front());
            if (f_valid_in && ret_en) due_q.push_back(cyc + RET_DLY);
            mdl_fvo <= (due_q.size() > 0) && (due_q[0] == cyc + 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [479:0] exp_flat();
        logic [479:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[CW*i +: CW] = exp_active[i];
        return r;
    endfunction

    // DRAIN lasts until the cycle after the last pending return, at least 1.
    function automatic int drain_len(input int t_commit);
        int d;
        d = 1;
        if (due_q.size() > 0) d = due_q[$] - t_commit + 1;
        if (d < 1) d = 1;
        if (d > DRAIN_TO) d = DRAIN_TO;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            exp_shadow[i] = ((i % 5) == 0) ? 24'h400000 : 24'h000000;
            exp_active[i] = exp_shadow[i];
        end
    endtask

    task automatic inputs_idle();
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        cfg_err_clr = 1'b0; s_valid_in = 1'b0; s_data_in = '0; man_fvo = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (a < NC) exp_shadow[a] = d;
    endtask

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            s_valid_in = 1'b1;
            s_data_in  = CW'($urandom);
            #1;
            chk("send_fvi", f_valid_in, 1);
            chk("send_fdata", f_data_in, s_data_in);
            tick();
        end
        s_valid_in = 1'b0;
    endtask

    task automatic clear_err();
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        #1 chk("err_cleared", cfg_err, 0);
    endtask

    // Commit issued in the current cycle; walks DRAIN, SWAP, FLUSH and the
    // first IDLE cycle, checking the visible behaviour of each.
    task automatic do_commit(input int exp_d, input bit gate, input bit dup_commit,
                             input bit we_flush, input bit cw_en, input logic [4:0] cw_addr,
                             input logic [CW-1:0] cw_data, input bit exp_err);
        logic [479:0] old_flat;
        old_flat = exp_flat();
        cfg_commit = 1'b1;
        if (cw_en) begin
            cfg_we = 1'b1; cfg_addr = cw_addr; cfg_wdata = cw_data;
            exp_shadow[cw_addr] = cw_data;
        end
        #1 chk("commit_idle", cfg_busy, 0);
        tick();
        cfg_commit = 1'b0; cfg_we = 1'b0;
        for (int i = 0; i < exp_d; i++) begin
            if (gate) begin s_valid_in = 1'b1; s_data_in = CW'($urandom); end
            cfg_commit = (dup_commit && i == 0);
            #1;
            chk("drain_busy", cfg_busy, 1);
            chk("drain_ready", s_ready, 0);
            chk("drain_fvi", f_valid_in, 0);
            chk("drain_flush", filt_flush, 0);
            chk("drain_coeff", coeff_flat, old_flat);
            tick();
        end
        s_valid_in = 1'b0; cfg_commit = 1'b0;
        #1;
        chk("swap_busy", cfg_busy, 1);
        chk("swap_flush", filt_flush, 0);
        chk("swap_coeff", coeff_flat, old_flat);
        for (int i = 0; i < NC; i++) exp_active[i] = exp_shadow[i];
        tick();
        for (int i = 0; i < FLUSH_CYC; i++) begin
            if (we_flush && i == 0) begin
                cfg_we = 1'b1; cfg_addr = 5'($urandom_range(0, NC - 1)); cfg_wdata = CW'($urandom);
            end else begin
                cfg_we = 1'b0;
            end
            #1;
            chk("flush_hi", filt_flush, 1);
            chk("flush_ready", s_ready, 0);
            chk("flush_coeff", coeff_flat, exp_flat());
            tick();
        end
        cfg_we = 1'b0;
        #1;
        chk("done_ready", s_ready, 1);
        chk("done_busy", cfg_busy, 0);
        chk("done_flush", filt_flush, 0);
        chk("done_err", cfg_err, exp_err);
    endtask

    initial begin
        int t;
        int d;
        inputs_idle();
        ret_en = 1'b1;
        rst = 1'b1;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_coeff", coeff_flat, exp_flat());
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_flush", filt_flush, 0);

        // Write without commit leaves the active bank alone
        wr(5'd3, 24'hC00000);
        #1;
        chk("nocommit_coeff", coeff_flat, exp_flat());
        chk("nocommit_err", cfg_err, 0);

        // Full rewrite with index+1, commit while idle
        for (int i = 0; i < NC; i++) wr(5'(i), CW'(i + 1));
        do_commit(1, 0, 0, 0, 0, 5'd0, '0, 0);

        // Random partial rewrite, then commit
        for (int k = 0; k < 8; k++) wr(5'($urandom_range(0, NC - 1)), CW'($urandom));
        do_commit(1, 0, 0, 0, 0, 5'd0, '0, 0);

        // Drain with three samples in flight, upstream kept valid during drain
        send(3);
        t = cyc;
        d = drain_len(t);
        chk("drain_len_model", d, 6);
        wr(5'($urandom_range(0, NC - 1)), CW'($urandom));
        t = cyc;
        d = drain_len(t);
        do_commit(d, 1, 0, 0, 0, 5'd0, '0, 0);

        // Timeout: one sample never returns
        ret_en = 1'b0;
        send(1);
        wr(5'd7, CW'($urandom));
        do_commit(DRAIN_TO, 0, 0, 0, 0, 5'd0, '0, 1);
        clear_err();
        ret_en = 1'b1;
        do_commit(1, 0, 0, 0, 0, 5'd0, '0, 0);

        // Illegal addresses in idle
        wr(5'd20, CW'($urandom));
        #1 chk("addr20_err", cfg_err, 1);
        chk("addr20_coeff", coeff_flat, exp_flat());
        clear_err();
        wr(5'd31, CW'($urandom));
        #1 chk("addr31_err", cfg_err, 1);
        clear_err();

        // Duplicate commit in DRAIN and a write during FLUSH
        wr(5'd12, CW'($urandom));
        do_commit(1, 0, 1, 1, 0, 5'd0, '0, 1);
        tick(); tick();
        #1 chk("one_swap_busy", cfg_busy, 0);
        clear_err();
        // Shadow must not hold the write attempted during FLUSH
        do_commit(1, 0, 0, 0, 0, 5'd0, '0, 0);

        // Same-cycle f_valid_in and f_valid_out keep the count
        ret_en = 1'b0;
        send(1);
        s_valid_in = 1'b1; s_data_in = CW'($urandom); man_fvo = 1'b1;
        tick();
        s_valid_in = 1'b0; man_fvo = 1'b1;
        tick();
        man_fvo = 1'b0;
        #1 chk("simul_err", cfg_err, 0);
        do_commit(1, 0, 0, 0, 0, 5'd0, '0, 0);

        // Same-cycle write and commit
        do_commit(1, 0, 0, 0, 1, 5'd0, 24'h200000, 0);
        chk("wr_commit_word0", coeff_flat[23:0], 24'h200000);

        // Counter saturates at PIPE_LAT+1: 12 sent, 9 returns empty it
        send(12);
        man_fvo = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        man_fvo = 1'b0;
        #1 chk("sat_err", cfg_err, 0);
        do_commit(1, 0, 0, 0, 0, 5'd0, '0, 0);
        ret_en = 1'b1;

        // Stray return sets the error and beats a same-cycle clear
        man_fvo = 1'b1; cfg_err_clr = 1'b1;
        tick();
        man_fvo = 1'b0; cfg_err_clr = 1'b0;
        #1 chk("stray_err_prio", cfg_err, 1);
        clear_err();

        // Reset in the middle of FLUSH
        for (int k = 0; k < 5; k++) wr(5'($urandom_range(0, NC - 1)), CW'($urandom));
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick(); tick(); tick();
        #1 chk("midrst_in_flush", filt_flush, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_coeff", coeff_flat, exp_flat());
        chk("midrst_ready", s_ready, 1);
        chk("midrst_flush", filt_flush, 0);
        chk("midrst_busy", cfg_busy, 0);
        // Shadow was reset too: a bare commit keeps passthrough
        do_commit(1, 0, 0, 0, 0, 5'd0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
